tmds_encoder_dvi: RTL and testbench

- Converts one 8-bit colour channel plus 2 control bits into a 10-bit DC-balanced TMDS symbol per DVI 1.0 §3.2.
- Sits inside dvi_generator, one instance per channel (ch0 blue + {vsync,hsync}, ch1 green, ch2 red).
- Consumes the registered dvi_* signals from the top level.
- Produces the 10-bit parallel symbol that feeds the 10:1 DDR serializer clocked by clk_pix_5x.
- Two-stage pipeline with running-disparity state.

---
 rtl/tmds_pkg.sv | 25 ++
 rtl/tmds_encoder_dvi.sv | 98 +++++++++
 tb/tb_tmds_encoder_dvi.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol width, control tokens and the byte popcount
// used by both the encoder and its reference model.
package tmds_pkg;

    localparam int TMDS_W = 10;

    typedef logic [TMDS_W-1:0] tmds_sym_t;

    // Control-period tokens, indexed by {ctrl[1], ctrl[0]}; bit 0 goes out first.
    localparam tmds_sym_t CTRL_TOKEN_00 = 10'b1101010100;
    localparam tmds_sym_t CTRL_TOKEN_01 = 10'b0010101011;
    localparam tmds_sym_t CTRL_TOKEN_10 = 10'b0101010100;
    localparam tmds_sym_t CTRL_TOKEN_11 = 10'b1010101011;

    // Number of set bits in a byte (0..8).
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_encoder_dvi.sv
// One DVI TMDS channel encoder. Stage 1 chooses the XOR/XNOR chain that
// minimises transitions; stage 2 applies DC balancing against the running
// disparity cnt, or emits a control token when de is low. Every cycle takes
// one input and produces one symbol; there is no flow control.
module tmds_encoder_dvi
    import tmds_pkg::*;
(
    input  logic       clk_pix,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic [1:0] ctrl_in,
    input  logic       de,
    output logic [9:0] tmds
);

    // Transition-minimised 9-bit word; bit 8 is 1 when the XOR chain was used.
    function automatic logic [8:0] tm_word(input logic [7:0] d);
        logic [8:0] q;
        logic [3:0] n1;
        logic       use_xnor;
        n1       = popcount8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    logic              s1_de;
    logic [1:0]        s1_ctrl;
    logic [8:0]        s1_q_m;
    logic signed [5:0] cnt;

    logic [3:0]        ones;
    logic signed [5:0] ones_s;
    logic signed [5:0] diff_oz;
    logic signed [5:0] diff_zo;
    tmds_sym_t         sym_next;
    logic signed [5:0] cnt_next;

    // Stage 1: register de/ctrl alongside the transition-minimised word.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            s1_de   <= 1'b0;
            s1_ctrl <= 2'b00;
            s1_q_m  <= 9'd0;
        end else begin
            s1_de   <= de;
            s1_ctrl <= ctrl_in;
            s1_q_m  <= tm_word(data_in);
        end
    end

    // Stage 2 combinational: pick the symbol form and the disparity update.
    always_comb begin
        ones     = popcount8(s1_q_m[7:0]);
        ones_s   = signed'({2'b00, ones});
        diff_oz  = (ones_s <<< 1) - 6'sd8;
        diff_zo  = 6'sd8 - (ones_s <<< 1);
        sym_next = CTRL_TOKEN_00;
        cnt_next = 6'sd0;
        if (!s1_de) begin
            unique case (s1_ctrl)
                2'b00:   sym_next = CTRL_TOKEN_00;
                2'b01:   sym_next = CTRL_TOKEN_01;
                2'b10:   sym_next = CTRL_TOKEN_10;
                default: sym_next = CTRL_TOKEN_11;
            endcase
            cnt_next = 6'sd0;
        end else if ((cnt == 6'sd0) || (ones == 4'd4)) begin
            sym_next = {~s1_q_m[8], s1_q_m[8],
                        s1_q_m[8] ? s1_q_m[7:0] : ~s1_q_m[7:0]};
            cnt_next = cnt + (s1_q_m[8] ? diff_oz : diff_zo);
        end else if (((cnt > 6'sd0) && (ones > 4'd4)) ||
                     ((cnt < 6'sd0) && (ones < 4'd4))) begin
            sym_next = {1'b1, s1_q_m[8], ~s1_q_m[7:0]};
            cnt_next = cnt + (s1_q_m[8] ? 6'sd2 : 6'sd0) + diff_zo;
        end else begin
            sym_next = {1'b0, s1_q_m[8], s1_q_m[7:0]};
            cnt_next = cnt - (s1_q_m[8] ? 6'sd0 : 6'sd2) + diff_oz;
        end
    end

    // Stage 2 register: output symbol and running disparity.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            tmds <= CTRL_TOKEN_00;
            cnt  <= 6'sd0;
        end else begin
            tmds <= sym_next;
            cnt  <= cnt_next;
        end
    end

endmodule

// File: tb/tb_tmds_encoder_dvi.sv
// Bench for tmds_encoder_dvi: directed vectors with hand-computed symbols,
// then a random stream checked against a reference encoder and a decoder.
module tb_tmds_encoder_dvi;
    import tmds_pkg::*;

    logic       clk_pix = 1'b0;
    logic       rst_n   = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [1:0] ctrl_in = 2'b00;
    logic       de      = 1'b0;
    logic [9:0] tmds;

    int n_checks = 0;
    int n_errors = 0;

    // Reference pipeline state.
    logic       m_de;
    logic [1:0] m_ctrl;
    logic [7:0] m_data;
    logic [8:0] m_qm;
    logic [9:0] m_out;
    int         m_cnt;
    logic       o_de;
    logic [1:0] o_ctrl;
    logic [7:0] o_data;
    int         run_disp;

    tmds_encoder_dvi dut (
        .clk_pix (clk_pix),
        .rst_n   (rst_n),
        .data_in (data_in),
        .ctrl_in (ctrl_in),
        .de      (de),
        .tmds    (tmds)
    );

    // Clock / reset block
    always #5 clk_pix = ~clk_pix;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [9:0] ref_token(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic logic [8:0] ref_qm(input logic [7:0] d);
        logic [8:0] q;
        int n1;
        bit xn;
        n1 = int'(popcount8(d));
        xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        q = '0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = !xn;
        return q;
    endfunction

    function automatic logic [9:0] ref_sym(input logic d_en, input logic [1:0] c,
                                           input logic [8:0] qm, input int cnt_in,
                                           output int cnt_out);
        int ones, zeros, q8;
        ones  = int'(popcount8(qm[7:0]));
        zeros = 8 - ones;
        q8    = int'(qm[8]);
        if (!d_en) begin
            cnt_out = 0;
            return ref_token(c);
        end
        if (cnt_in == 0 || ones == zeros) begin
            cnt_out = cnt_in + (q8 == 1 ? ones - zeros : zeros - ones);
            return {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        end
        if ((cnt_in > 0 && ones > zeros) || (cnt_in < 0 && zeros > ones)) begin
            cnt_out = cnt_in + 2 * q8 + (zeros - ones);
            return {1'b1, qm[8], ~qm[7:0]};
        end
        cnt_out = cnt_in - 2 * (1 - q8) + (ones - zeros);
        return {1'b0, qm[8], qm[7:0]};
    endfunction

    function automatic logic [7:0] ref_decode(input logic [9:0] s);
        logic [7:0] q;
        logic [7:0] d;
        q = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return d;
    endfunction

    task automatic model_reset();
        m_de = 1'b0; m_ctrl = 2'b00; m_data = 8'h00; m_qm = 9'd0;
        m_out = 10'b1101010100; m_cnt = 0;
        o_de = 1'b0; o_ctrl = 2'b00; o_data = 8'h00;
        run_disp = 0;
    endtask

    // Driver: apply one input, advance one clock, advance the reference model.
    task automatic drive(input logic d_en, input logic [1:0] c, input logic [7:0] d);
        int nc;
        de = d_en; ctrl_in = c; data_in = d;
        @(posedge clk_pix);
        m_out = ref_sym(m_de, m_ctrl, m_qm, m_cnt, nc);
        m_cnt = nc;
        o_de = m_de; o_ctrl = m_ctrl; o_data = m_data;
        m_de = d_en; m_ctrl = c; m_data = d; m_qm = ref_qm(d);
        #1;
    endtask

    // Scoreboard for the random phase: model match, decode, disparity bounds.
    task automatic check_stream();
        int c;
        c = dut.cnt;
        check("rnd_sym", int'(tmds), int'(m_out));
        check("rnd_cnt", c, m_cnt);
        check("rnd_cnt_bound", int'(c >= -16 && c <= 16), 1);
        if (o_de) begin
            check("rnd_decode", int'(ref_decode(tmds)), int'(o_data));
            run_disp += 2 * int'(popcount8(tmds[7:0]) + {3'b000, tmds[8]} + {3'b000, tmds[9]}) - 10;
            check("rnd_run_disp", int'(run_disp >= -20 && run_disp <= 20), 1);
        end else begin
            check("rnd_token", int'(tmds), int'(ref_token(o_ctrl)));
            run_disp = 0;
        end
    endtask

    initial begin
        int ctmp;
        model_reset();

        // Reset: de=1 with a colour byte present; output must hold token 00.
        rst_n = 1'b0; de = 1'b1; data_in = 8'hA5; ctrl_in = 2'b00;
        repeat (3) @(posedge clk_pix);
        #1;
        check("rst_tmds", int'(tmds), int'(10'b1101010100));
        ctmp = dut.cnt;
        check("rst_cnt", ctmp, 0);
        rst_n = 1'b1;
        #1;
        check("rel_tmds0", int'(tmds), int'(10'b1101010100));
        drive(1'b1, 2'b00, 8'hA5);
        check("rel_tmds1", int'(tmds), int'(10'b1101010100));
        drive(1'b0, 2'b00, 8'h00);
        check("rel_a5_model", int'(tmds), int'(m_out));

        // Control tokens, two cycles of latency.
        drive(1'b0, 2'b01, 8'h3C);
        drive(1'b0, 2'b10, 8'hC3);
        check("ctl_01", int'(tmds), int'(10'b0010101011));
        drive(1'b0, 2'b11, 8'hFF);
        check("ctl_10", int'(tmds), int'(10'b0101010100));
        drive(1'b0, 2'b00, 8'h81);
        check("ctl_11", int'(tmds), int'(10'b1010101011));
        drive(1'b0, 2'b00, 8'h00);
        check("ctl_00", int'(tmds), int'(10'b1101010100));

        // Balance from zero: two 8'h00 bytes after a control cycle.
        drive(1'b1, 2'b11, 8'h00);
        drive(1'b1, 2'b11, 8'h00);
        check("bal0_sym", int'(tmds), int'(10'b0100000000));
        ctmp = dut.cnt;
        check("bal0_cnt", ctmp, -8);
        drive(1'b0, 2'b00, 8'h00);
        check("bal1_sym", int'(tmds), int'(10'b1111111111));
        ctmp = dut.cnt;
        check("bal1_cnt", ctmp, 2);

        // XNOR path: 8'hFF after a control cycle.
        drive(1'b1, 2'b00, 8'hFF);
        drive(1'b0, 2'b00, 8'h00);
        check("xnor_sym", int'(tmds), int'(10'b1000000000));
        ctmp = dut.cnt;
        check("xnor_cnt", ctmp, -8);
        check("xnor_model", int'(tmds), int'(m_out));

        // de toggling every cycle: each data symbol starts from cnt=0.
        for (int i = 0; i < 24; i++) begin
            drive(i[0], 2'(i), 8'($urandom_range(0, 255)));
            check_stream();
        end

        // Random stream, de low for roughly 1 cycle in 16.
        for (int i = 0; i < 6000; i++) begin
            drive(($urandom_range(0, 15) != 0), 2'($urandom_range(0, 3)),
                  8'($urandom_range(0, 255)));
            check_stream();
        end

        // Reset mid-stream while disparity is nonzero.
        drive(1'b1, 2'b00, 8'h00);
        drive(1'b1, 2'b00, 8'h00);
        drive(1'b1, 2'b00, 8'h00);
        ctmp = dut.cnt;
        check("mid_cnt_nonzero", int'(ctmp != 0), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_tmds", int'(tmds), int'(10'b1101010100));
        ctmp = dut.cnt;
        check("mid_rst_cnt", ctmp, 0);
        repeat (2) @(posedge clk_pix);
        #3;
        model_reset();
        rst_n = 1'b1;
        #1;
        drive(1'b1, 2'b00, 8'h00);
        check("mid_rel_tok", int'(tmds), int'(10'b1101010100));
        drive(1'b1, 2'b00, 8'h00);
        check("mid_rel_sym", int'(tmds), int'(10'b0100000000));
        ctmp = dut.cnt;
        check("mid_rel_cnt", ctmp, -8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
